// File: rtl/arc4_encrypt_if.sv
// Start handshake and the three memory ports of arc4_encrypt, bundled for port connection.
// The engine sits on the slave modport; the start requester and the memories sit on master.
interface arc4_encrypt_if #(
  parameter int KEY_BYTES = 3
);
  logic                   en;
  logic                   rdy;
  logic [8*KEY_BYTES-1:0] key;

  logic [7:0]             pt_addr;
  logic [7:0]             pt_rddata;

  logic [7:0]             ct_addr;
  logic [7:0]             ct_wrdata;
  logic                   ct_wren;

  logic [7:0]             s_addr;
  logic [7:0]             s_wrdata;
  logic                   s_wren;
  logic [7:0]             s_rddata;

  // Handshake: a job is accepted on a rising clk edge where en=1 and rdy=1; key is
  // captured on that same edge. rdy stays low until the cycle after the last ct write.
  // Read data on pt_rddata/s_rddata belongs to the address presented one cycle earlier.
  modport slave (
    input  en, key, pt_rddata, s_rddata,
    output rdy, pt_addr, ct_addr, ct_wrdata, ct_wren, s_addr, s_wrdata, s_wren
  );

  modport master (
    output en, key, pt_rddata, s_rddata,
    input  rdy, pt_addr, ct_addr, ct_wrdata, ct_wren, s_addr, s_wrdata, s_wren
  );
endinterface

// File: rtl/arc4_encrypt.sv
// ARC4 engine: fills S, runs the keyed swap schedule, then XORs the keystream over a
// length-prefixed plaintext memory into a length-prefixed ciphertext memory.
module arc4_encrypt #(
  parameter int KEY_BYTES = 3
) (
  input  logic          clk,
  input  logic          rst,
  arc4_encrypt_if.slave bus,
  output logic [2:0]    dbg_state
);
  localparam int KB = 8 * KEY_BYTES;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    KSA  = 3'd2,
    LEN  = 3'd3,
    PRGA = 3'd4,
    DONE = 3'd5
  } state_e;

  // Every memory address is registered, so read data is consumed two phases after
  // the phase that chose the address.
  localparam logic [3:0] KSA_LAST  = 4'd5;
  localparam logic [3:0] LEN_LAST  = 4'd2;
  localparam logic [3:0] PRGA_LAST = 4'd8;

  state_e        state_q, state_d;
  logic [3:0]    phase_q, phase_d;
  logic          rdy_q, rdy_d;
  logic [KB-1:0] key_q, key_d;
  logic [7:0]    i_q, i_d;
  logic [7:0]    j_q, j_d;
  logic [7:0]    k_q, k_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    si_q, si_d;
  logic [7:0]    sj_q, sj_d;
  logic [7:0]    pt_q, pt_d;
  logic [7:0]    pt_addr_q, pt_addr_d;
  logic [7:0]    ct_addr_q, ct_addr_d;
  logic [7:0]    ct_wrdata_q, ct_wrdata_d;
  logic          ct_wren_q, ct_wren_d;
  logic [7:0]    s_addr_q, s_addr_d;
  logic [7:0]    s_wrdata_q, s_wrdata_d;
  logic          s_wren_q, s_wren_d;

  logic          accept;
  logic [7:0]    key_byte;
  logic [7:0]    j_ksa;
  logic [7:0]    j_prga;

  assign accept   = rdy_q && bus.en;
  // key_q is rotated one byte per KSA step, so its top byte is always keybyte[i mod KEY_BYTES].
  assign key_byte = key_q[KB-1 -: 8];
  assign j_ksa    = j_q + bus.s_rddata + key_byte;
  assign j_prga   = j_q + bus.s_rddata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      phase_q     <= 4'd0;
      rdy_q       <= 1'b0;
      key_q       <= '0;
      i_q         <= 8'd0;
      j_q         <= 8'd0;
      k_q         <= 8'd0;
      len_q       <= 8'd0;
      si_q        <= 8'd0;
      sj_q        <= 8'd0;
      pt_q        <= 8'd0;
      pt_addr_q   <= 8'd0;
      ct_addr_q   <= 8'd0;
      ct_wrdata_q <= 8'd0;
      ct_wren_q   <= 1'b0;
      s_addr_q    <= 8'd0;
      s_wrdata_q  <= 8'd0;
      s_wren_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      rdy_q       <= rdy_d;
      key_q       <= key_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      len_q       <= len_d;
      si_q        <= si_d;
      sj_q        <= sj_d;
      pt_q        <= pt_d;
      pt_addr_q   <= pt_addr_d;
      ct_addr_q   <= ct_addr_d;
      ct_wrdata_q <= ct_wrdata_d;
      ct_wren_q   <= ct_wren_d;
      s_addr_q    <= s_addr_d;
      s_wrdata_q  <= s_wrdata_d;
      s_wren_q    <= s_wren_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = INIT;
          phase_d = 4'd0;
        end
      end
      INIT: begin
        if (i_q == 8'hFF) begin
          state_d = KSA;
          phase_d = 4'd0;
        end
      end
      KSA: begin
        if (phase_q == KSA_LAST) begin
          phase_d = 4'd0;
          if (i_q == 8'hFF) state_d = LEN;
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end
      LEN: begin
        if (phase_q == LEN_LAST) begin
          phase_d = 4'd0;
          state_d = (bus.pt_rddata == 8'd0) ? DONE : PRGA;
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end
      PRGA: begin
        if (phase_q == PRGA_LAST) begin
          phase_d = 4'd0;
          if (k_q == len_q) state_d = DONE;
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        phase_d = 4'd0;
      end
      default: begin
        state_d = IDLE;
        phase_d = 4'd0;
      end
    endcase
  end

  always_comb begin
    rdy_d       = 1'b0;
    key_d       = key_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    len_d       = len_q;
    si_d        = si_q;
    sj_d        = sj_q;
    pt_d        = pt_q;
    pt_addr_d   = pt_addr_q;
    ct_addr_d   = ct_addr_q;
    ct_wrdata_d = ct_wrdata_q;
    ct_wren_d   = 1'b0;
    s_addr_d    = s_addr_q;
    s_wrdata_d  = s_wrdata_q;
    s_wren_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        rdy_d = !accept;
        if (accept) begin
          key_d = bus.key;
          i_d   = 8'd0;
        end
      end

      INIT: begin
        s_addr_d   = i_q;
        s_wrdata_d = i_q;
        s_wren_d   = 1'b1;
        i_d        = i_q + 8'd1;
        j_d        = 8'd0;
      end

      KSA: begin
        unique case (phase_q)
          4'd0: s_addr_d = i_q;
          4'd2: begin
            si_d     = bus.s_rddata;
            j_d      = j_ksa;
            s_addr_d = j_ksa;
          end
          4'd4: begin
            sj_d       = bus.s_rddata;
            s_addr_d   = i_q;
            s_wrdata_d = bus.s_rddata;
            s_wren_d   = 1'b1;
          end
          // Writing S[j] last means i==j ends with the original value in place.
          4'd5: begin
            s_addr_d   = j_q;
            s_wrdata_d = si_q;
            s_wren_d   = 1'b1;
            i_d        = i_q + 8'd1;
            key_d      = (key_q << 8) | (key_q >> (KB - 8));
          end
          default: ;
        endcase
      end

      LEN: begin
        unique case (phase_q)
          4'd0: pt_addr_d = 8'd0;
          4'd2: begin
            len_d       = bus.pt_rddata;
            ct_addr_d   = 8'd0;
            ct_wrdata_d = bus.pt_rddata;
            ct_wren_d   = 1'b1;
            i_d         = 8'd0;
            j_d         = 8'd0;
            k_d         = 8'd1;
          end
          default: ;
        endcase
      end

      PRGA: begin
        unique case (phase_q)
          4'd0: begin
            i_d      = i_q + 8'd1;
            s_addr_d = i_q + 8'd1;
          end
          4'd1: pt_addr_d = k_q;
          4'd2: begin
            si_d     = bus.s_rddata;
            j_d      = j_prga;
            s_addr_d = j_prga;
          end
          4'd3: pt_d = bus.pt_rddata;
          4'd4: begin
            sj_d       = bus.s_rddata;
            s_addr_d   = i_q;
            s_wrdata_d = bus.s_rddata;
            s_wren_d   = 1'b1;
          end
          4'd5: begin
            s_addr_d   = j_q;
            s_wrdata_d = si_q;
            s_wren_d   = 1'b1;
          end
          // Post-swap S[i]+S[j] is the same sum as the pre-swap pair.
          4'd6: s_addr_d = si_q + sj_q;
          4'd8: begin
            ct_addr_d   = k_q;
            ct_wrdata_d = pt_q ^ bus.s_rddata;
            ct_wren_d   = 1'b1;
            k_d         = k_q + 8'd1;
          end
          default: ;
        endcase
      end

      DONE: rdy_d = 1'b1;

      default: ;
    endcase
  end

  assign bus.rdy       = rdy_q;
  assign bus.pt_addr   = pt_addr_q;
  assign bus.ct_addr   = ct_addr_q;
  assign bus.ct_wrdata = ct_wrdata_q;
  assign bus.ct_wren   = ct_wren_q;
  assign bus.s_addr    = s_addr_q;
  assign bus.s_wrdata  = s_wrdata_q;
  assign bus.s_wren    = s_wren_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_arc4_encrypt.sv
// Bench for arc4_encrypt: behavioural ARC4 model, memory models, ct-write scoreboard,
// known-answer, boundary, reset and handshake scenarios plus random jobs.
module tb_arc4_encrypt;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] dbg_state;
  logic [2:0] idle_state;

  arc4_encrypt_if #(.KEY_BYTES(3)) bus ();

  arc4_encrypt #(.KEY_BYTES(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  logic [7:0]  pt_mem [256];
  logic [7:0]  ct_mem [256];
  logic [7:0]  s_mem  [256];
  logic [15:0] exp_q[$];
  logic [15:0] exp_e;
  int          n_checks  = 0;
  int          n_fail    = 0;
  int          ct_writes = 0;
  int          m_s  [256];
  int          m_ct [256];
  logic [7:0]  kat_ct [10];
  logic [7:0]  rt_ct  [10];

  // ---------------- memories: synchronous, one-cycle read latency ----------------
  always @(posedge clk) begin
    bus.pt_rddata <= pt_mem[bus.pt_addr];
    bus.s_rddata  <= s_mem[bus.s_addr];
    if (bus.s_wren)  s_mem[bus.s_addr]   <= bus.s_wrdata;
    if (bus.ct_wren) ct_mem[bus.ct_addr] <= bus.ct_wrdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard: every ct write must match the next expected {addr,data} ----------------
  always @(negedge clk) begin
    if (!rst && bus.ct_wren) begin
      ct_writes++;
      if (exp_q.size() == 0) begin
        check("ct_unexpected_write", {16'd0, bus.ct_addr, bus.ct_wrdata}, 32'hFFFF_FFFF);
      end else begin
        exp_e = exp_q.pop_front();
        check("ct_addr", 32'(bus.ct_addr), 32'(exp_e[15:8]));
        check("ct_data", 32'(bus.ct_wrdata), 32'(exp_e[7:0]));
      end
    end
  end

  // ---------------- behavioural ARC4 reference ----------------
  task automatic model_run(input logic [23:0] k, input int len);
    int i, j, t, kb;
    for (int n = 0; n < 256; n++) m_s[n] = n;
    j = 0;
    for (int n = 0; n < 256; n++) begin
      kb     = int'(k >> (8 * (2 - (n % 3)))) & 255;
      j      = (j + m_s[n] + kb) % 256;
      t      = m_s[n];
      m_s[n] = m_s[j];
      m_s[j] = t;
    end
    m_ct[0] = len;
    i = 0;
    j = 0;
    for (int n = 1; n <= len; n++) begin
      i       = (i + 1) % 256;
      j       = (j + m_s[i]) % 256;
      t       = m_s[i];
      m_s[i]  = m_s[j];
      m_s[j]  = t;
      m_ct[n] = int'(pt_mem[n]) ^ m_s[(m_s[i] + m_s[j]) % 256];
    end
  endtask

  task automatic push_expected(input int len);
    for (int n = 0; n <= len; n++) exp_q.push_back({8'(n), 8'(m_ct[n])});
  endtask

  task automatic wait_rdy(input int bound, output int cycles);
    cycles = 0;
    while (!bus.rdy && cycles <= bound) begin
      @(negedge clk);
      cycles++;
    end
    check("rdy_within_bound", 32'(cycles <= bound), 32'd1);
    check("idle_state_on_rdy", 32'(dbg_state), 32'(idle_state));
  endtask

  task automatic check_s_final(input string name);
    int bad = 0;
    for (int n = 0; n < 256; n++) if (int'(s_mem[n]) != m_s[n]) bad++;
    check(name, 32'(bad), 32'd0);
  endtask

  task automatic run_job(input logic [23:0] k, input int len, input string name);
    int cyc;
    model_run(k, len);
    push_expected(len);
    ct_writes = 0;
    @(negedge clk);
    bus.key = k;
    bus.en  = 1'b1;
    @(negedge clk);
    bus.en = 1'b0;
    check({name, "_accept"}, 32'(bus.rdy), 32'd0);
    wait_rdy(2048 + 10 * len, cyc);
    check({name, "_ct_writes"}, 32'(ct_writes), 32'(len + 1));
    check({name, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    check_s_final({name, "_s_final"});
  endtask

  task automatic load_plaintext();
    pt_mem[0] = 8'd9;
    pt_mem[1] = 8'h50; pt_mem[2] = 8'h6C; pt_mem[3] = 8'h61;
    pt_mem[4] = 8'h69; pt_mem[5] = 8'h6E; pt_mem[6] = 8'h74;
    pt_mem[7] = 8'h65; pt_mem[8] = 8'h78; pt_mem[9] = 8'h74;
  endtask

  task automatic check_kat(input string name);
    int bad = 0;
    for (int n = 0; n < 10; n++) if (ct_mem[n] !== kat_ct[n]) bad++;
    check(name, 32'(bad), 32'd0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int len;
    int bad;
    logic [23:0] rk;

    kat_ct = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    rt_ct  = '{8'h09, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    for (int n = 0; n < 256; n++) begin
      pt_mem[n] = 8'd0;
      ct_mem[n] = 8'd0;
      s_mem[n]  = 8'd0;
    end
    bus.en  = 1'b0;
    bus.key = 24'd0;

    // ---- reset state ----
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rdy", 32'(bus.rdy), 32'd0);
    check("reset_ct_wren", 32'(bus.ct_wren), 32'd0);
    check("reset_s_wren", 32'(bus.s_wren), 32'd0);
    check("reset_addrs", {8'd0, bus.pt_addr, bus.ct_addr, bus.s_addr}, 32'd0);
    check("reset_wrdata", {16'd0, bus.ct_wrdata, bus.s_wrdata}, 32'd0);
    idle_state = dbg_state;
    rst = 1'b0;
    @(negedge clk);
    check("rdy_after_reset", 32'(bus.rdy), 32'd1);

    // ---- known answer ----
    load_plaintext();
    model_run(24'h4B6579, 9);
    bad = 0;
    for (int n = 0; n < 10; n++) if (m_ct[n] != int'(kat_ct[n])) bad++;
    check("model_kat_pin", 32'(bad), 32'd0);
    run_job(24'h4B6579, 9, "kat");
    check_kat("kat_ct_mem");

    // ---- round trip: ciphertext fed back as plaintext ----
    for (int n = 0; n < 10; n++) pt_mem[n] = kat_ct[n];
    run_job(24'h4B6579, 9, "roundtrip");
    bad = 0;
    for (int n = 0; n < 10; n++) if (ct_mem[n] !== rt_ct[n]) bad++;
    check("roundtrip_ct_mem", 32'(bad), 32'd0);

    // ---- zero length ----
    pt_mem[0] = 8'd0;
    run_job(24'h000000, 0, "zero_len");
    check("zero_len_ct0", 32'(ct_mem[0]), 32'd0);

    // ---- max length, all-zero plaintext gives the raw keystream ----
    pt_mem[0] = 8'hFF;
    for (int n = 1; n < 256; n++) pt_mem[n] = 8'd0;
    run_job(24'h1C2D3E, 255, "max_len");
    check("max_len_ct0", 32'(ct_mem[0]), 32'hFF);

    // ---- random jobs ----
    for (int r = 0; r < 3; r++) begin
      len = $urandom_range(1, 40);
      rk  = 24'($urandom);
      pt_mem[0] = 8'(len);
      for (int n = 1; n <= len; n++) pt_mem[n] = 8'($urandom_range(0, 255));
      run_job(rk, len, "random");
    end

    // ---- reset during PRGA at k=3 ----
    load_plaintext();
    model_run(24'h4B6579, 9);
    push_expected(9);
    ct_writes = 0;
    @(negedge clk);
    bus.key = 24'h4B6579;
    bus.en  = 1'b1;
    @(negedge clk);
    bus.en = 1'b0;
    cyc = 0;
    while (ct_writes < 3 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    check("midreset_reached_k3", 32'(ct_writes), 32'd3);
    @(negedge clk);
    @(negedge clk);
    exp_q.delete();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midreset_ct_wren", 32'(bus.ct_wren), 32'd0);
    check("midreset_s_wren", 32'(bus.s_wren), 32'd0);
    check("midreset_rdy_low", 32'(bus.rdy), 32'd0);
    @(negedge clk);
    check("midreset_rdy_high", 32'(bus.rdy), 32'd1);
    repeat (20) @(negedge clk);
    check("midreset_no_more_ct", 32'(ct_writes), 32'd3);
    run_job(24'h4B6579, 9, "post_reset_kat");
    check_kat("post_reset_kat_ct_mem");

    // ---- en held across two jobs, key changed while busy ----
    pt_mem[0] = 8'd12;
    for (int n = 1; n <= 12; n++) pt_mem[n] = 8'($urandom_range(0, 255));
    model_run(24'hA1B2C3, 12);
    push_expected(12);
    model_run(24'h5D6E7F, 12);
    push_expected(12);
    ct_writes = 0;
    @(negedge clk);
    bus.key = 24'hA1B2C3;
    bus.en  = 1'b1;
    @(negedge clk);
    check("hs_accept1", 32'(bus.rdy), 32'd0);
    bus.key = 24'h5D6E7F;
    wait_rdy(2048 + 120, cyc);
    check("hs_first_job_writes", 32'(ct_writes), 32'd13);
    @(negedge clk);
    check("hs_accept2_same_cycle", 32'(bus.rdy), 32'd0);
    bus.en  = 1'b0;
    bus.key = 24'h000000;
    wait_rdy(2048 + 120, cyc);
    check("hs_total_writes", 32'(ct_writes), 32'd26);
    check("hs_queue_drained", 32'(exp_q.size()), 32'd0);
    check_s_final("hs_s_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/arc4_encrypt.md
Name: arc4_encrypt

Overview:
- ARC4 encryptor with a 24-bit key. It is the writer for the length-prefixed ciphertext memory that the cracking blocks read.
- Reads a length-prefixed plaintext memory, runs the ARC4 KSA and PRGA using an external 256x8 S memory, and writes a length-prefixed ciphertext memory.
- Started by the same en/rdy handshake used by the crack blocks. It generates ciphertext test images on-chip and also serves as the decrypt engine, since ARC4 is symmetric.

Parameters:
KEY_BYTES, 3, key length in bytes; key byte n = key[8*(KEY_BYTES-n)-1 -: 8], so byte 0 is the MSB byte.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
en  input  1  start request, sampled only while rdy=1
rdy  output  1  high when idle and able to accept en
key  input  24  ARC4 key, captured on the accepted-en cycle
pt_addr  output  8  plaintext memory address
pt_rddata  input  8  plaintext read data, valid 1 cycle after pt_addr
ct_addr  output  8  ciphertext memory address
ct_wrdata  output  8  ciphertext write data
ct_wren  output  1  ciphertext write strobe
s_addr  output  8  S memory address
s_wrdata  output  8  S memory write data
s_wren  output  1  S memory write strobe
s_rddata  input  8  S memory read data, valid 1 cycle after s_addr

Behaviour:
- Memory conventions:
  - All memories are synchronous RAMs with 1-cycle read latency; write-during-read on the same address is never issued.
  - Memory format: address 0 holds length L (0..255); message bytes are at addresses 1..L.
- Reset (rst=1 at a clock edge):
  - state=IDLE, rdy=0, pt_addr=ct_addr=s_addr=0, ct_wrdata=s_wrdata=0, ct_wren=s_wren=0.
  - rdy rises on the first clock after rst deasserts.
  - Reset mid-operation aborts immediately; no further writes occur. Partially written memory contents are undefined.
- Handshake:
  - en is accepted when en=1 and rdy=1 at a clock edge. On that edge rdy drops to 0 and key is latched.
  - en is ignored while busy. rdy returns to 1 on the cycle after the final ct write.
  - If en is held high, the next job starts on the first cycle rdy=1.
- State machine: IDLE -> INIT -> KSA -> LEN -> PRGA -> DONE -> IDLE.
- INIT:
  - Writes S[i]=i for i=0..255, one write per cycle, 256 cycles.
  - The 8-bit counter wraps 255->0 to exit.
- KSA:
  - Starts with j=0.
  - For i=0..255: read S[i]; j=(j+S[i]+keybyte[i mod KEY_BYTES]) mod 256; read S[j]; write S[i]=old S[j]; write S[j]=old S[i].
  - Values are held in internal registers. When i=j the swap must leave S[i] unchanged.
- LEN:
  - Read pt[0], latch L, write ct[0]=L.
  - If L=0, go straight to DONE with no PRGA accesses.
- PRGA:
  - Starts with i=j=0.
  - For k=1..L: i=i+1; read S[i]; j=j+S[i]; read S[j]; swap S[i]/S[j] (write both); read S[(S[i]+S[j]) mod 256] using post-swap values; read pt[k]; write ct[k]=pt[k] xor pad.
  - All index arithmetic is 8-bit and wraps mod 256.
  - The k counter must not overflow at L=255; use a 9-bit count or an equality compare.
- Write rules:
  - Exactly L+1 ct_wren pulses per job, in ascending address order, one pulse per address.
  - ct_wren and s_wren are single-cycle pulses. Addresses and data are stable during the write cycle.
- Latency: no exact cycle count is mandated. A job must finish (rdy=1) within 2048 + 10*L cycles of acceptance.
- key changing while busy has no effect.

Test Plan:
- Known answer: key=24'h4B6579 ("Key"), pt = {9,"Plaintext"} -> ct = {09,BB,F3,16,E8,D9,40,AF,0A,D3}; 10 ct writes; rdy returns to 1 within 2138 cycles.
- Round trip: feed the ciphertext from the known-answer test back as pt with the same key -> ct = {09,50,6C,61,69,6E,74,65,78,74}.
- Zero length: pt[0]=0, key=24'h000000 -> exactly one ct write (addr 0, data 00); S equals the KSA result for key 0; rdy returns to 1.
- Max length: L=255, pt bytes all 00 -> ct[0]=FF, and ct[1..255] equals the reference-model keystream for key 24'h1C2D3E; no address-0 rewrite after the length write; the job terminates.
- Reset mid-job: assert rst for 1 cycle during PRGA at k=3 -> next cycle ct_wren=0 and s_wren=0, rdy=1 one cycle later. A new job with en then produces the correct known-answer output.
- Handshake: hold en=1 across two jobs, changing key while busy -> second job starts the cycle rdy=1, using the key present at that edge; the first job is unaffected by the key change.
